legv8_bus_ctrl: RTL and testbench

Parametrised bus-cycle controller sitting between the LEGv8 control-word decode and the shared tristate data/address buses. It generalises the fixed 2-to-4 data-source and 1-to-2 address-source enable decode to N sources. It adds sequenced memory cycles with programmable wait states, a `mem_ready` handshake and a stall back to the control sequencer. A bus-timeout fault is optional.

---
 rtl/legv8_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_legv8_bus_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_bus_ctrl.sv
// legv8_bus_ctrl: N-source bus enable decode with sequenced memory cycles.
// Optional bus-timeout fault enabled by defining LEGV8_BUS_TIMEOUT_EN.
module legv8_bus_ctrl #(
   parameter int N_DATA      = 4,
   parameter int N_ADDR      = 2,
   parameter int WAIT_STATES = 1,
   parameter int TIMEOUT     = 16,
   localparam int DSW = (N_DATA > 1) ? $clog2(N_DATA) : 1,
   localparam int ASW = (N_ADDR > 1) ? $clog2(N_ADDR) : 1,
   localparam int TW  = $clog2(TIMEOUT + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic [DSW-1:0]    ds_sel,
   input  logic [ASW-1:0]    as_sel,
   input  logic              mw,
   input  logic [1:0]        size,
   input  logic              mem_ready,
   input  logic              fault_clr,
   output logic [N_DATA-1:0] data_en,
   output logic [N_ADDR-1:0] addr_en,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic              stall,
   output logic              done,
   output logic              fault
);

`ifdef LEGV8_BUS_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FAULT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ACCESS} state_t;
`endif

   localparam logic [DSW-1:0] LAST = DSW'(N_DATA - 1);

   state_t         state_q, state_d;
   logic [DSW-1:0] ds_q, ds_d;
   logic [ASW-1:0] as_q, as_d;
   logic           mw_q, mw_d;
   logic [1:0]     size_q, size_d;
   logic [3:0]     wait_q, wait_d;
`ifdef LEGV8_BUS_TIMEOUT_EN
   logic [TW-1:0]  to_q, to_d;
`else
   logic           unused_fault_clr;
   assign unused_fault_clr = fault_clr & (TIMEOUT > WAIT_STATES) & (TW > 0);
`endif

   logic           mem_op;
   logic           d_on, a_on;
   logic [DSW-1:0] d_sel;
   logic [ASW-1:0] a_sel;

   assign mem_op   = mw | (ds_sel == LAST);
   assign mem_size = size_q;

   // State, captured control word and counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ds_q    <= '0;
         as_q    <= '0;
         mw_q    <= 1'b0;
         size_q  <= 2'b00;
         wait_q  <= 4'd0;
`ifdef LEGV8_BUS_TIMEOUT_EN
         to_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         ds_q    <= ds_d;
         as_q    <= as_d;
         mw_q    <= mw_d;
         size_q  <= size_d;
         wait_q  <= wait_d;
`ifdef LEGV8_BUS_TIMEOUT_EN
         to_q    <= to_d;
`endif
      end
   end

   // Next state, capture, counters and bus/handshake outputs
   always_comb begin
      state_d = state_q;
      ds_d    = ds_q;
      as_d    = as_q;
      mw_d    = mw_q;
      size_d  = size_q;
      wait_d  = wait_q;
`ifdef LEGV8_BUS_TIMEOUT_EN
      to_d    = to_q;
`endif
      d_on    = 1'b0;
      a_on    = 1'b0;
      d_sel   = ds_sel;
      a_sel   = as_sel;
      mem_cs  = 1'b0;
      mem_we  = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
      fault   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req && mem_op) begin
               stall   = 1'b1;
               state_d = S_ACCESS;
               ds_d    = ds_sel;
               as_d    = as_sel;
               mw_d    = mw;
               size_d  = size;
               wait_d  = 4'(WAIT_STATES);
`ifdef LEGV8_BUS_TIMEOUT_EN
               to_d    = '0;
`endif
            end else if (req) begin
               d_on = 1'b1;
               a_on = 1'b1;
               done = 1'b1;
            end
         end
         S_ACCESS: begin
            a_on   = 1'b1;
            a_sel  = as_q;
            mem_cs = 1'b1;
            mem_we = mw_q;
            if (mw_q) begin
               d_on  = (ds_q != LAST);
               d_sel = ds_q;
            end else begin
               d_on  = 1'b1;
               d_sel = LAST;
            end
            if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
`ifdef LEGV8_BUS_TIMEOUT_EN
            to_d = to_q + 1'b1;
`endif
            if (wait_q == 4'd0 && mem_ready) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               stall = 1'b1;
`ifdef LEGV8_BUS_TIMEOUT_EN
               if (to_q == TW'(TIMEOUT - 1)) state_d = S_FAULT;
`endif
            end
         end
`ifdef LEGV8_BUS_TIMEOUT_EN
         S_FAULT: begin
            fault = 1'b1;
            if (fault_clr) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (!reset) begin
         d_on   = 1'b0;
         a_on   = 1'b0;
         mem_cs = 1'b0;
         mem_we = 1'b0;
         stall  = 1'b0;
         done   = 1'b0;
         fault  = 1'b0;
      end
   end

   // One-hot decode; out-of-range selects light nothing
   always_comb begin
      data_en = '0;
      addr_en = '0;
      for (int i = 0; i < N_DATA; i++)
         data_en[i] = d_on && (d_sel == DSW'(i));
      for (int i = 0; i < N_ADDR; i++)
         addr_en[i] = a_on && (a_sel == ASW'(i));
   end

endmodule

// File: tb/tb_legv8_bus_ctrl.sv
// tb_legv8_bus_ctrl: scoreboard bench for legv8_bus_ctrl.
// Two instances: 4/2 sources with 2 waits, 8/4 sources with 0 waits.
module tb_legv8_bus_ctrl;

   logic clock, reset;

   logic       a_req, a_mw, a_rdy, a_clr;
   logic [1:0] a_ds, a_size;
   logic [0:0] a_as;
   logic [3:0] a_data_en;
   logic [1:0] a_addr_en, a_mem_size;
   logic       a_mem_cs, a_mem_we, a_stall, a_done, a_fault;

   logic       b_req, b_mw, b_rdy, b_clr;
   logic [2:0] b_ds;
   logic [1:0] b_as, b_size;
   logic [7:0] b_data_en;
   logic [3:0] b_addr_en;
   logic [1:0] b_mem_size;
   logic       b_mem_cs, b_mem_we, b_stall, b_done, b_fault;

   int total = 0;
   int bad   = 0;
   logic [18:0] sb[$];

   legv8_bus_ctrl #(
      .N_DATA(4), .N_ADDR(2), .WAIT_STATES(2), .TIMEOUT(16)
   ) dut_a (
      .clock(clock), .reset(reset), .req(a_req), .ds_sel(a_ds),
      .as_sel(a_as), .mw(a_mw), .size(a_size), .mem_ready(a_rdy),
      .fault_clr(a_clr), .data_en(a_data_en), .addr_en(a_addr_en),
      .mem_cs(a_mem_cs), .mem_we(a_mem_we), .mem_size(a_mem_size),
      .stall(a_stall), .done(a_done), .fault(a_fault)
   );

   legv8_bus_ctrl #(
      .N_DATA(8), .N_ADDR(4), .WAIT_STATES(0), .TIMEOUT(16)
   ) dut_b (
      .clock(clock), .reset(reset), .req(b_req), .ds_sel(b_ds),
      .as_sel(b_as), .mw(b_mw), .size(b_size), .mem_ready(b_rdy),
      .fault_clr(b_clr), .data_en(b_data_en), .addr_en(b_addr_en),
      .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_size(b_mem_size),
      .stall(b_stall), .done(b_done), .fault(b_fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ctl = {cs, we, stall, done, fault}
   function automatic logic [18:0] mk(logic [7:0] de, logic [3:0] ae,
                                      logic [4:0] ctl, logic [1:0] sz);
      return {de, ae, ctl, sz};
   endfunction

   function automatic logic [18:0] obs_a();
      return {4'b0, a_data_en, 2'b0, a_addr_en, a_mem_cs, a_mem_we,
              a_stall, a_done, a_fault, a_mem_size};
   endfunction

   function automatic logic [18:0] obs_b();
      return {b_data_en, b_addr_en, b_mem_cs, b_mem_we,
              b_stall, b_done, b_fault, b_mem_size};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [18:0] e, o;
      #3;
      sb.push_back('0);
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL rst_init_a got=%h want=%h", o, e);
      end
      sb.push_back('0);
      o = obs_b(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL rst_init_b got=%h want=%h", o, e);
      end
      tick();
      reset = 1'b1;
      a_req = 1'b1; a_ds = 2'd3; a_as = 1'b0; a_size = 2'b11;
      sb.push_back(mk(8'h00, 4'h0, 5'b00100, 2'b00));
      @(negedge clock);
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL rst_c0 got=%h want=%h", o, e);
      end
      tick();
      a_req = 1'b0;
      sb.push_back(mk(8'h08, 4'h1, 5'b10100, 2'b11));
      @(negedge clock);
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL rst_c1 got=%h want=%h", o, e);
      end
      #2 reset = 1'b0;
      #1;
      sb.push_back('0);
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL rst_async got=%h want=%h", o, e);
      end
      #1 reset = 1'b1;
      tick();
      a_rdy = 1'b1;
      sb.push_back('0);
      @(negedge clock);
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL rst_idle got=%h want=%h", o, e);
      end
      a_rdy = 1'b0;
   endtask

   task automatic test_reg_op();
      logic [18:0] e, o;
      tick();
      a_req = 1'b1; a_ds = 2'd1; a_as = 1'b0; a_mw = 1'b0;
      b_req = 1'b1; b_ds = 3'd5; b_as = 2'd2; b_mw = 1'b0;
      sb.push_back(mk(8'h02, 4'h1, 5'b00010, 2'b00));
      sb.push_back(mk(8'h20, 4'h4, 5'b00010, 2'b00));
      @(negedge clock);
      o = obs_a(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL regop_a got=%h want=%h", o, e);
      end
      o = obs_b(); e = sb.pop_front(); total++;
      if (o !== e) begin
         bad++; $display("FAIL regop_b got=%h want=%h", o, e);
      end
      a_req = 1'b0; b_req = 1'b0;
   endtask

   task automatic test_read();
      logic [18:0] e, o;
      for (int k = 0; k <= 4; k++) begin
         tick();
         a_rdy = 1'b1; a_mw = 1'b0;
         if (k == 0) begin
            a_req = 1'b1; a_ds = 2'd3; a_as = 1'b1; a_size = 2'b10;
            e = mk(8'h00, 4'h0, 5'b00100, 2'b00);
         end else if (k <= 2) begin
            a_req = 1'b1; a_ds = 2'd0; a_as = 1'b0; a_size = 2'b01;
            e = mk(8'h08, 4'h2, 5'b10100, 2'b10);
         end else if (k == 3) begin
            a_req = 1'b0;
            e = mk(8'h08, 4'h2, 5'b10010, 2'b10);
         end else begin
            e = mk(8'h00, 4'h0, 5'b00000, 2'b10);
         end
         sb.push_back(e);
         @(negedge clock);
         o = obs_a(); e = sb.pop_front(); total++;
         if (o !== e) begin
            bad++; $display("FAIL read k=%0d got=%h want=%h", k, o, e);
         end
      end
      a_rdy = 1'b0;
   endtask

   task automatic test_write();
      logic [18:0] e, o;
      for (int k = 0; k <= 5; k++) begin
         tick();
         b_req = (k == 0); b_mw = 1'b1; b_ds = 3'd1; b_as = 2'd0;
         b_size = 2'b11; b_rdy = (k == 4);
         if (k == 0) e = mk(8'h00, 4'h0, 5'b00100, 2'b00);
         else if (k <= 3) e = mk(8'h02, 4'h1, 5'b11100, 2'b11);
         else if (k == 4) e = mk(8'h02, 4'h1, 5'b11010, 2'b11);
         else e = mk(8'h00, 4'h0, 5'b00000, 2'b11);
         sb.push_back(e);
         @(negedge clock);
         o = obs_b(); e = sb.pop_front(); total++;
         if (o !== e) begin
            bad++; $display("FAIL write k=%0d got=%h want=%h", k, o, e);
         end
      end
      for (int k = 0; k <= 2; k++) begin
         tick();
         b_req = (k == 0); b_mw = 1'b1; b_ds = 3'd7; b_as = 2'd2;
         b_size = 2'b00; b_rdy = 1'b1;
         if (k == 0) e = mk(8'h00, 4'h0, 5'b00100, 2'b11);
         else if (k == 1) e = mk(8'h00, 4'h4, 5'b11010, 2'b00);
         else e = mk(8'h00, 4'h0, 5'b00000, 2'b00);
         sb.push_back(e);
         @(negedge clock);
         o = obs_b(); e = sb.pop_front(); total++;
         if (o !== e) begin
            bad++; $display("FAIL wr_last k=%0d got=%h want=%h", k, o, e);
         end
      end
      b_mw = 1'b0; b_rdy = 1'b0;
   endtask

   task automatic test_timeout();
      logic [18:0] e, o;
      for (int k = 0; k <= 25; k++) begin
         tick();
         a_req = (k == 0); a_ds = 2'd3; a_as = 1'b0; a_mw = 1'b0;
         a_size = 2'b01; a_rdy = 1'b0; a_clr = 1'b0;
         if (k == 0) e = mk(8'h00, 4'h0, 5'b00100, 2'b10);
         else if (k <= 16) e = mk(8'h08, 4'h1, 5'b10100, 2'b01);
`ifdef LEGV8_BUS_TIMEOUT_EN
         else if (k <= 20) begin
            a_req = (k == 18); a_ds = 2'd1; a_as = 1'b1;
            a_clr = (k == 20);
            e = mk(8'h00, 4'h0, 5'b00001, 2'b01);
         end else if (k == 21) begin
            a_req = 1'b1; a_size = 2'b00; a_rdy = 1'b1;
            e = mk(8'h00, 4'h0, 5'b00100, 2'b01);
         end else if (k <= 23) begin
            a_rdy = 1'b1;
            e = mk(8'h08, 4'h1, 5'b10100, 2'b00);
         end else if (k == 24) begin
            a_rdy = 1'b1;
            e = mk(8'h08, 4'h1, 5'b10010, 2'b00);
         end else e = mk(8'h00, 4'h0, 5'b00000, 2'b00);
`else
         else if (k <= 20) begin
            a_clr = (k == 18);
            e = mk(8'h08, 4'h1, 5'b10100, 2'b01);
         end else if (k == 21) begin
            a_rdy = 1'b1;
            e = mk(8'h08, 4'h1, 5'b10010, 2'b01);
         end else e = mk(8'h00, 4'h0, 5'b00000, 2'b01);
`endif
         sb.push_back(e);
         @(negedge clock);
         o = obs_a(); e = sb.pop_front(); total++;
         if (o !== e) begin
            bad++; $display("FAIL timeout k=%0d got=%h want=%h", k, o, e);
         end
      end
      a_rdy = 1'b0; a_clr = 1'b0;
   endtask

   task automatic test_done_vs_timeout();
      logic [18:0] e, o;
      for (int k = 0; k <= 17; k++) begin
         tick();
         b_req = (k == 0); b_mw = 1'b0; b_ds = 3'd7; b_as = 2'd1;
         b_size = 2'b01; b_rdy = (k == 16);
         if (k == 0) e = mk(8'h00, 4'h0, 5'b00100, 2'b00);
         else if (k <= 15) e = mk(8'h80, 4'h2, 5'b10100, 2'b01);
         else if (k == 16) e = mk(8'h80, 4'h2, 5'b10010, 2'b01);
         else e = mk(8'h00, 4'h0, 5'b00000, 2'b01);
         sb.push_back(e);
         @(negedge clock);
         o = obs_b(); e = sb.pop_front(); total++;
         if (o !== e) begin
            bad++; $display("FAIL race k=%0d got=%h want=%h", k, o, e);
         end
      end
      b_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [18:0] e, o;
      for (int k = 0; k <= 4; k++) begin
         tick();
         b_req = (k <= 3); b_mw = 1'b0; b_ds = 3'd7; b_as = 2'd3;
         b_size = (k >= 2) ? 2'b11 : 2'b10; b_rdy = 1'b1;
         if (k == 0) e = mk(8'h00, 4'h0, 5'b00100, 2'b01);
         else if (k == 1) e = mk(8'h80, 4'h8, 5'b10010, 2'b10);
         else if (k == 2) e = mk(8'h00, 4'h0, 5'b00100, 2'b10);
         else if (k == 3) e = mk(8'h80, 4'h8, 5'b10010, 2'b11);
         else e = mk(8'h00, 4'h0, 5'b00000, 2'b11);
         sb.push_back(e);
         @(negedge clock);
         o = obs_b(); e = sb.pop_front(); total++;
         if (o !== e) begin
            bad++; $display("FAIL b2b k=%0d got=%h want=%h", k, o, e);
         end
         total++;
         if (!$onehot0(b_data_en) || !$onehot0(b_addr_en)) begin
            bad++;
            $display("FAIL onehot k=%0d got=%h/%h want=onehot0",
                     k, b_data_en, b_addr_en);
         end
      end
      b_rdy = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      a_req = 1'b0; a_mw = 1'b0; a_rdy = 1'b0; a_clr = 1'b0;
      a_ds = '0; a_as = '0; a_size = '0;
      b_req = 1'b0; b_mw = 1'b0; b_rdy = 1'b0; b_clr = 1'b0;
      b_ds = '0; b_as = '0; b_size = '0;
      test_reset();
      test_reg_op();
      test_read();
      test_write();
      test_timeout();
      test_done_vs_timeout();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
